// File: rtl/cfg_bank_pkg.sv
// Shared types and timing defaults for the configuration memory bank programmer.
package cfg_bank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    PULSE,
    HOLD,
    FIN
  } state_t;

  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_bank_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times the SETUP, PULSE and HOLD phases.
module cfg_bank_phase_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cfg_mem_bank_programmer.sv
// Streams bitline words into a tile-column config bank and pulses one wordline per row.
// Optional even-parity check on each word is enabled with CFG_BANK_PARITY_EN.
module cfg_mem_bank_programmer
  import cfg_bank_pkg::*;
#(
  parameter int BL_WIDTH     = 40,
  parameter int WL_WIDTH     = 4,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BL_WIDTH-1:0] cfg_data,
  input  logic                cfg_valid,
`ifdef CFG_BANK_PARITY_EN
  input  logic                cfg_parity,
  output logic                parity_err,
`endif
  output logic                cfg_ready,
  output logic [BL_WIDTH-1:0] bl_out,
  output logic [WL_WIDTH-1:0] wl_out,
  output logic                busy,
  output logic                done
);

  localparam int RW = cnt_width(WL_WIDTH);
  localparam int MAX_PHASE = (SETUP_CYCLES > PULSE_CYCLES)
                           ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                           : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int TW = cnt_width(MAX_PHASE);
  localparam logic [RW-1:0] ROW_LAST = RW'(WL_WIDTH - 1);

  state_t              state, state_next;
  logic [RW-1:0]       row, row_next;
  logic [BL_WIDTH-1:0] bl_next;
  logic [WL_WIDTH-1:0] wl_next;
  logic                tmr_load, tmr_zero;
  logic [TW-1:0]       tmr_val;
  logic                handshake, par_ok;

  assign handshake = (state == LOAD) && cfg_valid && cfg_ready;

`ifdef CFG_BANK_PARITY_EN
  assign par_ok = ((^cfg_data) == cfg_parity);

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      parity_err <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      parity_err <= 1'b0;
    end else if (handshake && !par_ok && !abort) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  cfg_bank_phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (prog_clk),
    .rst_n    (prog_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next = state;
    row_next   = row;
    bl_next    = bl_out;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = LOAD;
          row_next   = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          if (par_ok) begin
            state_next = SETUP;
            bl_next    = cfg_data;
            tmr_load   = 1'b1;
            tmr_val    = TW'(SETUP_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_next = PULSE;
          tmr_load   = 1'b1;
          tmr_val    = TW'(PULSE_CYCLES - 1);
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_next = HOLD;
          tmr_load   = 1'b1;
          tmr_val    = TW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          if (row == ROW_LAST) begin
            state_next = FIN;
          end else begin
            state_next = LOAD;
            row_next   = row + RW'(1);
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && state != IDLE) begin
      state_next = IDLE;
      tmr_load   = 1'b0;
    end

    // Outputs are registered, so they are derived from the state being entered.
    if (state_next == IDLE) begin
      row_next = '0;
    end
    if (state_next != SETUP && state_next != PULSE && state_next != HOLD) begin
      bl_next = '0;
    end
    wl_next = (state_next == PULSE) ? (WL_WIDTH'(1) << row_next) : '0;
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state     <= IDLE;
      row       <= '0;
      bl_out    <= '0;
      wl_out    <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      row       <= row_next;
      bl_out    <= bl_next;
      wl_out    <= wl_next;
      cfg_ready <= (state_next == LOAD);
      busy      <= (state_next != IDLE);
      done      <= (state_next == FIN);
    end
  end

endmodule
